l2_learn_switch: RTL and testbench

Downstream neighbour of the parser stage. Consumes the parser's output stream (metadata words followed by the original packet) and learns source MAC → ingress port bindings in a small fully associative table. Looks up the destination MAC and writes the egress port into metadata word 0. Forwards the whole stream unchanged otherwise, with a fixed 2-cycle latency.

---
 rtl/l2_learn_switch_if.sv | 19 +
 rtl/l2_learn_switch.sv | 154 +++++++++++++++
 tb/tb_l2_learn_switch.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_learn_switch_if.sv
// Metadata stream bundle between the parser stage, the learning switch and its downstream consumer.
interface l2_learn_switch_if;
    logic         metadata_in_valid;
    logic [133:0] metadata_in;
    logic         ready_in;
    logic         ready_out;
    logic         metadata_out_valid;
    logic [133:0] metadata_out;

    modport master (
        output metadata_in_valid, metadata_in, ready_in,
        input  ready_out, metadata_out_valid, metadata_out
    );

    modport slave (
        input  metadata_in_valid, metadata_in, ready_in,
        output ready_out, metadata_out_valid, metadata_out
    );
endinterface

// File: rtl/l2_learn_switch.sv
// L2 learning switch: learns smac->ingress port, looks up dmac and patches egress into meta0.
// Fixed two-cycle stream latency, no backpressure.
module l2_learn_switch #(
    parameter int unsigned TABLE_SIZE = 16,
    parameter logic [31:0] AGE_PERIOD = 32'd125000000,
    parameter logic [7:0]  FLOOD_PORT = 8'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    l2_learn_switch_if.slave      sw,
    output logic [5:0]            entry_count,
    output logic [15:0]           err_count
);
    localparam int unsigned WORD_W = 134;
    localparam int unsigned MAC_W  = 48;
    localparam int unsigned PORT_W = 8;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned IDX_W  = $clog2(TABLE_SIZE);

    typedef enum logic [1:0] {IDLE, META, PKT} phase_t;

    phase_t              phase;
    logic                s1_valid;
    logic [WORD_W-1:0]   s1_word;
    logic                s1_meta0;
    logic                out_valid_q;
    logic [WORD_W-1:0]   out_word_q;

    logic [TABLE_SIZE-1:0] tbl_valid;
    logic [TABLE_SIZE-1:0] tbl_age;
    logic [MAC_W-1:0]      tbl_mac  [TABLE_SIZE];
    logic [PORT_W-1:0]     tbl_port [TABLE_SIZE];
    logic [IDX_W-1:0]      rr_ptr;
    logic [31:0]           age_cnt;

    logic [1:0]        in_tag_c;
    logic [MAC_W-1:0]  in_dmac_c;
    logic [MAC_W-1:0]  in_smac_c;
    logic              meta1_ok_c;
    logic              learn_c;
    logic              tick_c;
    logic              d_hit_c;
    logic [PORT_W-1:0] d_port_c;
    logic              s_hit_c;
    logic [IDX_W-1:0]  s_idx_c;
    logic              free_found_c;
    logic [IDX_W-1:0]  free_idx_c;
    logic [IDX_W-1:0]  learn_idx_c;
    logic [PORT_W-1:0] egress_c;
    logic [CNT_W-1:0]  pop_c;

    assign sw.ready_out          = sw.ready_in;
    assign sw.metadata_out_valid = out_valid_q;
    assign sw.metadata_out       = out_word_q;

    assign in_tag_c   = sw.metadata_in[133:132];
    assign in_dmac_c  = sw.metadata_in[127:80];
    assign in_smac_c  = sw.metadata_in[79:32];
    assign meta1_ok_c = s1_meta0 && sw.metadata_in_valid && (in_tag_c == 2'b11);
    assign learn_c    = meta1_ok_c && !in_smac_c[40];
    assign tick_c     = (age_cnt == AGE_PERIOD - 32'd1);
    assign egress_c   = (d_hit_c && !in_dmac_c[40]) ? d_port_c : FLOOD_PORT;
    assign learn_idx_c = s_hit_c ? s_idx_c : (free_found_c ? free_idx_c : rr_ptr);

    // Parallel dmac/smac match, lowest free slot and occupancy over the pre-write table
    always_comb begin
        d_hit_c      = 1'b0;
        d_port_c     = FLOOD_PORT;
        s_hit_c      = 1'b0;
        s_idx_c      = '0;
        free_found_c = 1'b0;
        free_idx_c   = '0;
        pop_c        = '0;
        for (int i = 0; i < int'(TABLE_SIZE); i++) begin
            if (!d_hit_c && tbl_valid[i] && (tbl_mac[i] == in_dmac_c)) begin
                d_hit_c  = 1'b1;
                d_port_c = tbl_port[i];
            end
            if (!s_hit_c && tbl_valid[i] && (tbl_mac[i] == in_smac_c)) begin
                s_hit_c = 1'b1;
                s_idx_c = IDX_W'(i);
            end
            if (!free_found_c && !tbl_valid[i]) begin
                free_found_c = 1'b1;
                free_idx_c   = IDX_W'(i);
            end
            pop_c = pop_c + CNT_W'(tbl_valid[i]);
        end
    end

    // Phase tracking, s1 capture and output patch
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase       <= IDLE;
            s1_valid    <= 1'b0;
            s1_word     <= '0;
            s1_meta0    <= 1'b0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            s1_valid    <= sw.metadata_in_valid;
            s1_word     <= sw.metadata_in;
            s1_meta0    <= sw.metadata_in_valid && (phase == IDLE) && (in_tag_c == 2'b01);
            out_valid_q <= s1_valid;
            out_word_q  <= s1_word;
            if (s1_meta0) begin
                out_word_q[119:112] <= meta1_ok_c ? egress_c : FLOOD_PORT;
            end
            if (sw.metadata_in_valid) begin
                case (phase)
                    IDLE:    if (in_tag_c == 2'b01) phase <= META;
                    META:    if (in_tag_c == 2'b00) phase <= PKT;
                    PKT:     if (in_tag_c == 2'b10) phase <= IDLE;
                    default: phase <= IDLE;
                endcase
            end
        end
    end

    // Table learn/aging; a learn on a tick cycle overrides aging for its entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tbl_valid   <= '0;
            tbl_age     <= '0;
            rr_ptr      <= '0;
            age_cnt     <= '0;
            entry_count <= '0;
            err_count   <= '0;
            for (int i = 0; i < int'(TABLE_SIZE); i++) begin
                tbl_mac[i]  <= '0;
                tbl_port[i] <= '0;
            end
        end else begin
            age_cnt     <= tick_c ? 32'd0 : age_cnt + 32'd1;
            entry_count <= pop_c;
            if (tick_c) begin
                tbl_valid <= tbl_valid & tbl_age;
                tbl_age   <= '0;
            end
            if (learn_c) begin
                tbl_valid[learn_idx_c] <= 1'b1;
                tbl_age[learn_idx_c]   <= 1'b1;
                tbl_mac[learn_idx_c]   <= in_smac_c;
                tbl_port[learn_idx_c]  <= s1_word[127:120];
                if (!s_hit_c && !free_found_c) begin
                    rr_ptr <= rr_ptr + IDX_W'(1);
                end
            end
            if (s1_meta0 && !meta1_ok_c && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_l2_learn_switch.sv
// Directed plus randomized bench for l2_learn_switch against a cycle-level table model.
module tb_l2_learn_switch;
    localparam int unsigned TS    = 16;
    localparam int          AP    = 100;
    localparam logic [7:0]  FLOOD = 8'hFF;
    localparam int P_IDLE = 0, P_META = 1, P_PKT = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  entry_count;
    logic [15:0] err_count;

    l2_learn_switch_if bus ();

    l2_learn_switch #(.TABLE_SIZE(TS), .AGE_PERIOD(32'(AP)), .FLOOD_PORT(FLOOD)) dut (
        .clk(clk), .reset(reset), .sw(bus.slave),
        .entry_count(entry_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: MAC table plus expected register contents
    bit           m_valid [TS];
    bit           m_age   [TS];
    logic [47:0]  m_mac   [TS];
    logic [7:0]   m_port  [TS];
    int           m_rr, m_cycles, m_phase, m_err, m_ec;
    bit           m_s1_v, m_s1_m0, m_ov;
    logic [133:0] m_s1_w, m_o;
    logic [7:0]   eg_obs;

    task automatic chk(input string tag, input logic [133:0] got, input logic [133:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(TS); i++) begin
            m_valid[i] = 0; m_age[i] = 0; m_mac[i] = '0; m_port[i] = '0;
        end
        m_rr = 0; m_cycles = 0; m_phase = P_IDLE; m_err = 0; m_ec = 0;
        m_s1_v = 0; m_s1_m0 = 0; m_s1_w = '0; m_ov = 0; m_o = '0;
    endtask

    function automatic int popcount();
        int n = 0;
        for (int i = 0; i < int'(TS); i++) n += int'(m_valid[i]);
        return n;
    endfunction

    // One clock: drive a word, advance the model, then compare everything after the edge
    task automatic cyc(input bit v, input logic [133:0] w);
        logic [133:0] o;
        logic [47:0]  dm, sm;
        logic [7:0]   eg;
        bit           good, tick, learn;
        int           ti;
        bus.metadata_in_valid = v;
        bus.metadata_in       = w;
        bus.ready_in          = 1'($urandom);
        m_ec = popcount();
        m_ov = m_s1_v;
        o    = m_s1_w;
        dm   = w[127:80];
        sm   = w[79:32];
        good = m_s1_m0 && v && (w[133:132] == 2'b11);
        if (m_s1_m0) begin
            eg = FLOOD;
            if (good && !dm[40])
                for (int i = 0; i < int'(TS); i++)
                    if (m_valid[i] && m_mac[i] == dm) eg = m_port[i];
            o[119:112] = eg;
            if (!good && m_err < 65535) m_err++;
        end
        m_o = o;
        tick = (m_cycles % AP) == AP - 1;
        m_cycles++;
        learn = good && !sm[40];
        ti = -1;
        if (learn) begin
            for (int i = 0; i < int'(TS); i++) if (ti < 0 && m_valid[i] && m_mac[i] == sm) ti = i;
            for (int i = 0; i < int'(TS); i++) if (ti < 0 && !m_valid[i]) ti = i;
            if (ti < 0) begin
                ti = m_rr;
                m_rr = (m_rr + 1) % int'(TS);
            end
        end
        if (tick)
            for (int i = 0; i < int'(TS); i++) begin
                if (!m_age[i]) m_valid[i] = 0;
                m_age[i] = 0;
            end
        if (learn) begin
            m_valid[ti] = 1; m_age[ti] = 1; m_mac[ti] = sm; m_port[ti] = m_s1_w[127:120];
        end
        m_s1_m0 = v && (m_phase == P_IDLE) && (w[133:132] == 2'b01);
        if (v) begin
            if (m_phase == P_IDLE && w[133:132] == 2'b01) m_phase = P_META;
            else if (m_phase == P_META && w[133:132] == 2'b00) m_phase = P_PKT;
            else if (m_phase == P_PKT && w[133:132] == 2'b10) m_phase = P_IDLE;
        end
        m_s1_v = v;
        m_s1_w = w;
        @(posedge clk);
        #1;
        chk("out_valid", 134'(bus.metadata_out_valid), 134'(m_ov));
        chk("out_word", bus.metadata_out, m_o);
        chk("entry_count", 134'(entry_count), 134'(m_ec));
        chk("err_count", 134'(err_count), 134'(m_err));
        chk("ready_out", 134'(bus.ready_out), 134'(bus.ready_in));
    endtask

    function automatic logic [133:0] rnd_word(input logic [1:0] tag);
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return {tag, 4'($urandom()), r};
    endfunction

    function automatic logic [133:0] mk_meta0(input logic [7:0] ing);
        logic [133:0] w;
        w = rnd_word(2'b01);
        w[127:120] = ing;
        return w;
    endfunction

    function automatic logic [133:0] mk_meta1(input logic [47:0] dm, input logic [47:0] sm);
        logic [133:0] w;
        w = rnd_word(2'b11);
        w[127:80] = dm;
        w[79:32]  = sm;
        return w;
    endfunction

    // Well-formed packet; egress seen on the meta0 output word is left in eg_obs
    task automatic send_pkt(input logic [7:0] ing, input logic [47:0] dm, input logic [47:0] sm);
        cyc(1, mk_meta0(ing));
        cyc(1, mk_meta1(dm, sm));
        eg_obs = bus.metadata_out[119:112];
        cyc(1, rnd_word(2'b00));
        cyc(1, rnd_word(2'b01));
        cyc(1, rnd_word(2'b10));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 134'(bus.metadata_out_valid), 134'(0));
        chk("rst_out_word", bus.metadata_out, 134'(0));
        chk("rst_entry_count", 134'(entry_count), 134'(0));
        chk("rst_err_count", 134'(err_count), 134'(0));
        model_reset();
        #1;
        reset = 1'b1;
    endtask

    logic [47:0] pool_mac;
    logic [47:0] d_r, s_r;

    initial begin
        bus.metadata_in_valid = 1'b0;
        bus.metadata_in       = '0;
        bus.ready_in          = 1'b0;
        model_reset();
        #12;
        chk("init_out_valid", 134'(bus.metadata_out_valid), 134'(0));
        chk("init_out_word", bus.metadata_out, 134'(0));
        chk("init_entry_count", 134'(entry_count), 134'(0));
        do_reset();

        // Learn then hit, group dmac, group smac
        send_pkt(8'h03, 48'h0000_0000_000B, 48'h0000_0000_000A);
        chk("A_egress", 134'(eg_obs), 134'(8'hFF));
        chk("A_count", 134'(entry_count), 134'(1));
        send_pkt(8'h05, 48'h0000_0000_000A, 48'h0000_0000_000B);
        chk("B_egress", 134'(eg_obs), 134'(8'h03));
        chk("B_count", 134'(entry_count), 134'(2));
        send_pkt(8'h07, 48'h0000_0000_000B, 48'h0000_0000_000C);
        chk("C_egress", 134'(eg_obs), 134'(8'h05));
        send_pkt(8'h09, 48'h0100_0000_000B, 48'h0000_0000_000D);
        chk("D_group_dmac", 134'(eg_obs), 134'(8'hFF));
        send_pkt(8'h0A, 48'h0000_0000_000C, 48'h0100_0000_00EE);
        chk("E_egress", 134'(eg_obs), 134'(8'h07));
        chk("E_count", 134'(entry_count), 134'(4));

        // Bubble between meta0 and meta1
        cyc(1, mk_meta0(8'h02));
        cyc(0, rnd_word(2'b11));
        chk("err_egress", 134'(bus.metadata_out[119:112]), 134'(8'hFF));
        cyc(1, mk_meta1(48'h0000_0000_000A, 48'h0000_0000_000F));
        cyc(1, rnd_word(2'b00));
        cyc(1, rnd_word(2'b10));
        cyc(0, '0);
        chk("err_count_1", 134'(err_count), 134'(1));
        chk("err_no_learn", 134'(entry_count), 134'(4));

        // Fill past capacity: round-robin replaces entry 0
        do_reset();
        for (int i = 0; i < 17; i++)
            send_pkt(8'(8'h10 + i), 48'h0000_0000_0002, 48'(48'h100 + i));
        chk("fill_count", 134'(entry_count), 134'(16));
        send_pkt(8'h01, 48'h0000_0000_0100, 48'h0100_0000_0001);
        chk("fill_evicted", 134'(eg_obs), 134'(8'hFF));
        send_pkt(8'h01, 48'h0000_0000_0102, 48'h0100_0000_0001);
        chk("fill_kept", 134'(eg_obs), 134'(8'h12));
        chk("fill_count2", 134'(entry_count), 134'(16));

        // Aging: two ticks without refresh drop the entry
        do_reset();
        send_pkt(8'h04, 48'h0000_0000_0001, 48'h0000_0000_0055);
        chk("age_learned", 134'(entry_count), 134'(1));
        repeat (250) cyc(0, rnd_word(2'($urandom())));
        chk("age_count", 134'(entry_count), 134'(0));
        send_pkt(8'h06, 48'h0000_0000_0055, 48'h0100_0000_0001);
        chk("age_flood", 134'(eg_obs), 134'(8'hFF));

        // Randomized traffic over a small MAC pool, stray tags and bubbles
        for (int p = 0; p < 120; p++) begin
            pool_mac = 48'($urandom_range(0, 20));
            d_r = ($urandom_range(0, 7) == 0) ? (pool_mac | 48'h0100_0000_0000) : pool_mac;
            s_r = 48'($urandom_range(0, 20));
            if ($urandom_range(0, 9) == 0) s_r = s_r | 48'h0100_0000_0000;
            if ($urandom_range(0, 4) == 0) s_r = d_r;
            if ($urandom_range(0, 3) == 0) cyc(0, rnd_word(2'($urandom())));
            if ($urandom_range(0, 9) == 0) cyc(1, rnd_word(2'($urandom())));
            cyc(1, mk_meta0(8'($urandom_range(0, 15))));
            if ($urandom_range(0, 7) == 0) cyc(0, rnd_word(2'b11));
            cyc(1, mk_meta1(d_r, s_r));
            cyc(1, rnd_word(2'b00));
            cyc(1, rnd_word(2'b01));
            for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
                if ($urandom_range(0, 4) == 0) cyc(0, rnd_word(2'b10));
                cyc(1, rnd_word(2'b11));
            end
            cyc(1, rnd_word(2'b10));
        end

        // Reset mid-packet, then an orphan tail, then a clean packet
        send_pkt(8'h01, 48'h0000_0000_0001, 48'h0000_0000_0002);
        cyc(1, mk_meta0(8'h02));
        cyc(1, mk_meta1(48'h0000_0000_0003, 48'h0000_0000_0004));
        cyc(1, rnd_word(2'b00));
        do_reset();
        cyc(1, rnd_word(2'b10));
        cyc(0, '0);
        cyc(0, '0);
        chk("post_rst_tail", 134'(entry_count), 134'(0));
        send_pkt(8'h08, 48'h0000_0000_0004, 48'h0000_0000_0009);
        chk("post_rst_egress", 134'(eg_obs), 134'(8'hFF));
        chk("post_rst_count", 134'(entry_count), 134'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
